// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the digit-serial multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles needed to consume the whole multiplier.
  function automatic int calc_iter(input int in2_w, input int dig_w);
    return (in2_w + dig_w - 1) / dig_w;
  endfunction

endpackage

// File: rtl/mult_seq_digit.sv
// One iteration of the shift-add loop: acc_hi + mcand * digit, built as a
// ripple of per-bit conditional adds.
module mult_seq_digit #(
  parameter int INPUT1_WIDTH = 64,
  parameter int DIGIT_WIDTH  = 4
) (
  input  logic [INPUT1_WIDTH-1:0]             mcand,
  input  logic [DIGIT_WIDTH-1:0]              digit,
  input  logic [INPUT1_WIDTH-1:0]             acc_hi,
  output logic [INPUT1_WIDTH+DIGIT_WIDTH-1:0] psum
);
  localparam int SW = INPUT1_WIDTH + DIGIT_WIDTH;

  // part[i] holds the running sum after digit bits [i-1:0]; cannot overflow SW.
  logic [DIGIT_WIDTH:0][SW-1:0] part;

  assign part[0] = SW'(acc_hi);

  for (genvar i = 0; i < DIGIT_WIDTH; i++) begin : g_bit
    assign part[i+1] = part[i] + (digit[i] ? (SW'(mcand) << i) : '0);
  end

  assign psum = part[DIGIT_WIDTH];

endmodule

// File: rtl/mult_seq_wrapper.sv
// Digit-serial multiplier with valid/ready handshakes on both sides.
// Define MULT_SEQ_SIGNED_EN to honour op_signed (two's-complement operands).
module mult_seq_wrapper
  import mult_seq_pkg::*;
#(
  parameter int INPUT1_WIDTH = 64,
  parameter int INPUT2_WIDTH = 64,
  parameter int DIGIT_WIDTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INPUT1_WIDTH-1:0]              in0,
  input  logic [INPUT2_WIDTH-1:0]              in1,
  input  logic                                 op_signed,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] outp
);
  localparam int ITER   = calc_iter(INPUT2_WIDTH, DIGIT_WIDTH);
  localparam int LOW_W  = ITER * DIGIT_WIDTH;
  localparam int ACC_W  = INPUT1_WIDTH + LOW_W;
  localparam int PROD_W = INPUT1_WIDTH + INPUT2_WIDTH;
  localparam int CNT_W  = $clog2(ITER + 1);

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt;
  logic [INPUT1_WIDTH-1:0]          mcand;
  logic [ACC_W-1:0]                 acc, acc_nxt;
  logic [INPUT1_WIDTH+DIGIT_WIDTH-1:0] psum;
  logic [INPUT1_WIDTH-1:0]          mag0;
  logic [INPUT2_WIDTH-1:0]          mag1;
  logic [PROD_W-1:0]                prod, prod_fix;
  logic                             accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_W'(ITER - 1));

`ifdef MULT_SEQ_SIGNED_EN
  // Sign-magnitude conditioning: multiply magnitudes, negate the result.
  logic neg0, neg1, neg_q;

  assign neg0 = op_signed & in0[INPUT1_WIDTH-1];
  assign neg1 = op_signed & in1[INPUT2_WIDTH-1];
  assign mag0 = neg0 ? -in0 : in0;
  assign mag1 = neg1 ? -in1 : in1;

  always_ff @(posedge clk) begin
    if (rst)         neg_q <= 1'b0;
    else if (accept) neg_q <= neg0 ^ neg1;
  end

  assign prod_fix = neg_q ? -prod : prod;
`else
  logic op_signed_unused;

  assign op_signed_unused = op_signed;
  assign mag0             = in0;
  assign mag1             = in1;
  assign prod_fix         = prod;
`endif

  // acc = {running high part, unconsumed multiplier}; shifts right one digit per cycle.
  mult_seq_digit #(
    .INPUT1_WIDTH(INPUT1_WIDTH),
    .DIGIT_WIDTH (DIGIT_WIDTH)
  ) u_digit (
    .mcand (mcand),
    .digit (acc[DIGIT_WIDTH-1:0]),
    .acc_hi(acc[ACC_W-1:LOW_W]),
    .psum  (psum)
  );

  assign acc_nxt = ACC_W'({psum, acc[LOW_W-1:0]} >> DIGIT_WIDTH);
  assign prod    = acc_nxt[PROD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? BUSY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      outp  <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mcand <= mag0;
      acc   <= {{INPUT1_WIDTH{1'b0}}, LOW_W'(mag1)};
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_nxt;
      if (last) outp <= prod_fix;
    end
  end

endmodule

// File: tb/tb_mult_seq_wrapper.sv
// Directed bench: default 64x64/4 instance plus a 16x12/5 instance.
module tb_mult_seq_wrapper;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, op_signed, out_valid, out_ready;
  logic [63:0]  in0, in1;
  logic [127:0] outp;

  logic         in_valid2, in_ready2, op_signed2, out_valid2, out_ready2;
  logic [15:0]  in0_2;
  logic [11:0]  in1_2;
  logic [27:0]  outp2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_seq_wrapper dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .op_signed(op_signed), .out_valid(out_valid),
    .out_ready(out_ready), .outp(outp)
  );

  mult_seq_wrapper #(.INPUT1_WIDTH(16), .INPUT2_WIDTH(12), .DIGIT_WIDTH(5)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in0(in0_2), .in1(in1_2), .op_signed(op_signed2), .out_valid(out_valid2),
    .out_ready(out_ready2), .outp(outp2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid, starting from the caller's count.
  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [127:0] p, output int lat);
    in0 = a; in1 = b; op_signed = s; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    wait_valid(lat);
    p = outp;
    tick();
  endtask

  logic [127:0] p;
  int           lat;
  int           rises;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; op_signed = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in0_2 = '0; in1_2 = '0; op_signed2 = 1'b0; out_ready2 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_outp",      outp,            128'd0);

    do_op(64'd3, 64'd5, 1'b0, p, lat);
    chk("3x5_outp", p, 128'd15);
    chk("3x5_lat",  128'(lat), 128'd16);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, p, lat);
    chk("max_outp", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

`ifdef MULT_SEQ_SIGNED_EN
    do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, p, lat);
    chk("sgn_m2x3", p, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, p, lat);
    chk("sgn_m1xm1", p, 128'd1);
`else
    do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, p, lat);
    chk("uns_m2x3", p, 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFA);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, p, lat);
    chk("uns_m1xm1", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
`endif

    // Stall in DONE, then back-to-back accept on the release edge.
    in0 = 64'd6; in1 = 64'd7; op_signed = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    wait_valid(lat);
    chk("stall_lat",  128'(lat), 128'd16);
    chk("stall_outp0", outp, 128'd42);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_outp",  outp,            128'd42);
      chk("stall_rdy",   128'(in_ready),  128'd0);
    end
    in0 = 64'd9; in1 = 64'd11; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_rdy", 128'(in_ready), 128'd1);
    tick();
    chk("b2b_busy_valid", 128'(out_valid), 128'd0);
    // Operand changes and in_valid during BUSY must be ignored.
    in0 = 64'd123; in1 = 64'd456;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_rdy", 128'(in_ready), 128'd0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_lat",  128'(lat), 128'd16);
    chk("b2b_outp", outp, 128'd99);
    tick();
    chk("b2b_idle_rdy", 128'(in_ready), 128'd1);

    // Reset in cycle 8 of BUSY aborts without emitting a product.
    in0 = 64'd3; in1 = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 128'(out_valid), 128'd0);
    chk("abort_outp",  outp,            128'd0);
    chk("abort_rdy",   128'(in_ready),  128'd1);
    rises = 0;
    repeat (20) begin
      tick();
      if (out_valid) rises++;
    end
    chk("abort_no_prod", 128'(rises), 128'd0);

    // Non-multiple digit width: 12-bit multiplier in 5-bit digits, ITER=3.
    in0_2 = 16'd1000; in1_2 = 12'd4095; in_valid2 = 1'b1; out_ready2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 100) begin
      tick();
      lat++;
    end
    chk("d5_lat",  128'(lat),   128'd3);
    chk("d5_outp", 128'(outp2), 128'd4095000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_wrapper.md
MULT_SEQ_WRAPPER -- requirements
Module: mult_seq_wrapper

Interface
REQ-001 SHALL have parameter INPUT1_WIDTH, default 64, multiplicand width in bits.
REQ-002 SHALL have parameter INPUT2_WIDTH, default 64, multiplier width in bits.
REQ-003 SHALL have parameter DIGIT_WIDTH, default 4, multiplier bits consumed per iteration cycle (1..INPUT2_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operand pair present.
REQ-007 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port in0  input  INPUT1_WIDTH  multiplicand.
REQ-009 SHALL have port in1  input  INPUT2_WIDTH  multiplier.
REQ-010 SHALL have port op_signed  input  1  1 = two's-complement operands, sampled with in0/in1.
REQ-011 SHALL have port out_valid  output  1  product available.
REQ-012 SHALL have port out_ready  input  1  consumer takes product.
REQ-013 SHALL have port outp  output  INPUT1_WIDTH+INPUT2_WIDTH  product.

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-015 SHALL assert in_ready in IDLE, and in DONE when out_ready=1; deasserted in BUSY.
REQ-016 SHALL accept a transaction on a rising edge where in_valid && in_ready; operands and op_signed registered at that edge, then go to BUSY with iteration counter = 0.
REQ-017 SHALL define ITER = ceil(INPUT2_WIDTH/DIGIT_WIDTH); in BUSY, process one DIGIT_WIDTH slice of the multiplier per cycle, LSB slice first, shift-add into the accumulator.
REQ-018 SHALL enter DONE on the ITER-th edge after acceptance, so out_valid is high exactly ITER cycles after the accept edge.
REQ-019 SHALL hold outp and out_valid stable in DONE until out_ready=1.
REQ-020 SHALL, on an edge in DONE with out_ready=1, return to IDLE, or go straight to BUSY if in_valid=1 on that edge (back-to-back, no bubble).
REQ-021 SHALL ignore in_valid in BUSY; in0/in1/op_signed changes there do not affect the in-flight result.
REQ-022 SHALL produce outp = in0*in1 unsigned, full width, no truncation or overflow, when op_signed=0.
REQ-023 SHALL zero-pad the top slice when INPUT2_WIDTH is not a multiple of DIGIT_WIDTH.
REQ-024 SHALL keep outp at its previous value outside DONE; its value there is not a contract.

Reset
REQ-025 SHALL, on rst=1 at an edge, force IDLE, counter 0, accumulator and outp 0, out_valid 0, in_ready 1 on the following cycle.
REQ-026 SHALL abort an in-flight transaction on reset mid-BUSY or mid-DONE with no product emitted.
REQ-027 SHALL give rst priority over a simultaneous accept or out_ready.

Configuration
REQ-028 SHALL support macro MULT_SEQ_SIGNED_EN: when defined, op_signed=1 yields the two's-complement product of signed in0 and in1 (sign-magnitude pre/post conditioning, no extra latency).
REQ-029 SHALL, without MULT_SEQ_SIGNED_EN, keep the op_signed port but ignore it (always unsigned) and omit the conditioning logic.

Structure
REQ-030 SHALL place the FSM state enum typedef and the ITER-computation function in shared package mult_seq_pkg.
REQ-031 SHALL implement the per-cycle digit partial-product-and-add as sub-module mult_seq_digit (INPUT1_WIDTH x DIGIT_WIDTH product plus accumulator add).

Verification (defaults 64/64/4, ITER=16)
REQ-032 SHALL test: in0=3, in1=5, op_signed=0, out_ready=1 -> outp=15, out_valid rises exactly 16 cycles after accept.
REQ-033 SHALL test: in0=in1=0xFFFF_FFFF_FFFF_FFFF unsigned -> outp=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-034 SHALL test with MULT_SEQ_SIGNED_EN: in0=-2, in1=3, op_signed=1 -> outp=128'hFFFF...FFFA; in0=in1=-1 -> outp=1; without macro, same stimulus gives unsigned product.
REQ-035 SHALL test: out_ready held 0 for 10 cycles in DONE -> outp/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> next operands accepted same edge, next result 16 cycles later.
REQ-036 SHALL test: rst=1 at cycle 8 of BUSY -> next cycle IDLE, out_valid=0, outp=0, in_ready=1; no stale product appears.
REQ-037 SHALL test with DIGIT_WIDTH=5, INPUT2_WIDTH=12: ITER=3, in0=1000, in1=4095 -> outp=4095000 after 3 cycles.
